// File: rtl/iir_biquad_mc.sv
// rtl/iir_biquad_mc.sv - multi-channel time-multiplexed biquad IIR sharing one signed MAC
// Each accepted sample takes five MAC cycles plus one write-back cycle; history lives per channel.
module iir_biquad_mc #(
   parameter int N    = 16,
   parameter int FRAC = 14,
   parameter int CH   = 4,
   parameter int CW   = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CW-1:0]       in_ch,
   input  logic signed [N-1:0] in_data,
   input  logic signed [N-1:0] a0,
   input  logic signed [N-1:0] a1,
   input  logic signed [N-1:0] a2,
   input  logic signed [N-1:0] b1,
   input  logic signed [N-1:0] b2,
   input  logic                bypass,
   output logic                out_valid,
   output logic [CW-1:0]       out_ch,
   output logic signed [N-1:0] out_data,
   output logic                sat
);

   localparam int AW = 2 * N + 3;
   localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC - 1);
   localparam logic signed [AW-1:0] YMAX = AW'((1 << (N - 1)) - 1);
   localparam logic signed [AW-1:0] YMIN = ~YMAX;

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                state;
   logic [2:0]            step;
   logic signed [AW-1:0]  acc, acc_next, rnd, shr;
   logic signed [N-1:0]   x_r, a0_r, a1_r, a2_r, b1_r, b2_r;
   logic [CW-1:0]         ch_r;
   logic                  byp_r;
   logic signed [N-1:0]   x1_m [CH];
   logic signed [N-1:0]   x2_m [CH];
   logic signed [N-1:0]   y1_m [CH];
   logic signed [N-1:0]   y2_m [CH];
   logic signed [N-1:0]   h_x1, h_x2, h_y1, h_y2, mul_c, mul_d, y_clip;
   logic signed [2*N-1:0] prod;
   logic                  ch_ok, clip_hi, clip_lo;

   always_comb begin
      ch_ok = 32'(ch_r) < CH;
      h_x1 = '0;
      h_x2 = '0;
      h_y1 = '0;
      h_y2 = '0;
      if (ch_ok) begin
         h_x1 = x1_m[ch_r];
         h_x2 = x2_m[ch_r];
         h_y1 = y1_m[ch_r];
         h_y2 = y2_m[ch_r];
      end
      case (step)
         3'd0:    begin mul_c = a0_r; mul_d = x_r;  end
         3'd1:    begin mul_c = a1_r; mul_d = h_x1; end
         3'd2:    begin mul_c = a2_r; mul_d = h_x2; end
         3'd3:    begin mul_c = b1_r; mul_d = h_y1; end
         default: begin mul_c = b2_r; mul_d = h_y2; end
      endcase
      prod = $signed({{N{mul_c[N-1]}}, mul_c} * {{N{mul_d[N-1]}}, mul_d});
      // feedback terms (steps 3 and 4) subtract
      if (step >= 3'd3)
         acc_next = acc - $signed({{3{prod[2*N-1]}}, prod});
      else
         acc_next = acc + $signed({{3{prod[2*N-1]}}, prod});
      rnd     = acc + HALF;
      shr     = rnd >>> FRAC;
      clip_hi = shr > YMAX;
      clip_lo = shr < YMIN;
      if (clip_hi)
         y_clip = {1'b0, {(N-1){1'b1}}};
      else if (clip_lo)
         y_clip = {1'b1, {(N-1){1'b0}}};
      else
         y_clip = shr[N-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         step      <= '0;
         acc       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_data  <= '0;
         sat       <= 1'b0;
         x_r       <= '0;
         ch_r      <= '0;
         byp_r     <= 1'b0;
         a0_r      <= '0;
         a1_r      <= '0;
         a2_r      <= '0;
         b1_r      <= '0;
         b2_r      <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: ;
            MAC: begin
               acc  <= acc_next;
               step <= step + 3'd1;
               if (step == 3'd4) begin
                  state    <= DONE;
                  in_ready <= 1'b1;
               end
            end
            DONE: begin
               if (ch_ok) begin
                  out_valid <= 1'b1;
                  out_ch    <= ch_r;
                  out_data  <= byp_r ? x_r : y_clip;
                  sat       <= byp_r ? 1'b0 : (clip_hi | clip_lo);
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // acceptance in IDLE or DONE overrides the transition above
         if (state != MAC && in_valid) begin
            state    <= MAC;
            in_ready <= 1'b0;
            step     <= '0;
            acc      <= '0;
            x_r      <= in_data;
            ch_r     <= in_ch;
            byp_r    <= bypass;
            a0_r     <= a0;
            a1_r     <= a1;
            a2_r     <= a2;
            b1_r     <= b1;
            b2_r     <= b2;
         end
      end
   end

   // clr shares priority with reset so it wins over a coincident write-back
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         for (int i = 0; i < CH; i++) begin
            x1_m[i] <= '0;
            x2_m[i] <= '0;
            y1_m[i] <= '0;
            y2_m[i] <= '0;
         end
      end else if (state == DONE && ch_ok && !byp_r) begin
         x2_m[ch_r] <= h_x1;
         x1_m[ch_r] <= x_r;
         y2_m[ch_r] <= h_y1;
         y1_m[ch_r] <= y_clip;
      end
   end

endmodule
